// File: rtl/image_frame_sequencer.sv
// Frame sequencer for a raster filter datapath: loads a WIDTH x DEPTH image, steps the filter over
// every pixel, then drains the result, walking (x,y) in raster order in each phase.
module image_frame_sequencer #(
  parameter int unsigned WIDTH = 410,
  parameter int unsigned DEPTH = 361,
  parameter int unsigned CW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          load_en,
  output logic          proc_en,
  output logic [1:0]    filt_sel,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] XLast = CW'(WIDTH - 1);
  localparam logic [CW-1:0] YLast = CW'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StProc, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]    filt_sel_q, filt_sel_d;
  logic          step;
  logic          last;

  assign last = (x_q == XLast) && (y_q == YLast);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    filt_sel_d = filt_sel_q;
    step       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          filt_sel_d = mode;
          x_d        = '0;
          y_d        = '0;
          state_d    = StLoad;
        end
      end
      StLoad:  step = in_valid;
      StProc:  step = 1'b1;
      StDrain: step = out_ready;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (step) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (last) begin
        case (state_q)
          StLoad:  state_d = StProc;
          StProc:  state_d = StDrain;
          StDrain: state_d = StDone;
          default: state_d = state_q;
        endcase
      end
    end

    // Abort overrides any same-cycle accept or phase change.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      x_d     = '0;
      y_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      filt_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      filt_sel_q <= filt_sel_d;
    end
  end

  // load_en is the raw-image write strobe, so it follows in_valid within LOAD.
  assign in_ready  = (state_q == StLoad);
  assign load_en   = in_ready & in_valid;
  assign proc_en   = (state_q == StProc);
  assign out_valid = (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign filt_sel  = filt_sel_q;
  assign x         = x_q;
  assign y         = y_q;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Bench for image_frame_sequencer: table of whole-frame scenarios plus hand-written abort and
// reset sequences; expected raster coordinates are queued per phase and popped as strobes appear.
module tb_image_frame_sequencer;

  localparam int W  = 4;
  localparam int D  = 3;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst, start, abort, in_valid, out_ready;
  logic [1:0]    mode;
  logic          in_ready, out_valid, load_en, proc_en, busy, done;
  logic [1:0]    filt_sel;
  logic [CW-1:0] x, y;

  image_frame_sequencer #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .load_en   (load_en),
    .proc_en   (proc_en),
    .filt_sel  (filt_sel),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } xy_t;

  typedef struct {
    string    name;
    logic [1:0] mode;
    bit       toggle;
    int       stall_idx;
    int       stall_len;
    int       exp_filt;
    int       exp_loads;
    int       exp_procs;
    int       exp_drains;
  } vec_t;

  xy_t load_q[$];
  xy_t proc_q[$];
  xy_t drain_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int nload, nproc, ndrain, ndone;
  int exp_filt;
  logic done_busy;
  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_frame();
    xy_t e;
    load_q.delete();
    proc_q.delete();
    drain_q.delete();
    for (int yy = 0; yy < D; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        e.x = CW'(xx);
        e.y = CW'(yy);
        load_q.push_back(e);
        proc_q.push_back(e);
        drain_q.push_back(e);
      end
    end
    nload = 0; nproc = 0; ndrain = 0; ndone = 0;
  endtask

  // Settle inputs, observe the current cycle, then cross one rising edge.
  task automatic step();
    xy_t e;
    #1;
    if (!rst) begin
      chk("strobe_excl", (int'(load_en) + int'(proc_en) + int'(out_valid) <= 1) ? 1 : 0, 1);
      if (load_en) begin
        nload++;
        if (load_q.size() == 0) chk("load_extra", 1, 0);
        else begin
          e = load_q.pop_front();
          chk("load_x", int'(x), int'(e.x));
          chk("load_y", int'(y), int'(e.y));
          chk("load_filt", int'(filt_sel), exp_filt);
        end
      end
      if (proc_en) begin
        nproc++;
        if (proc_q.size() == 0) chk("proc_extra", 1, 0);
        else begin
          e = proc_q.pop_front();
          chk("proc_x", int'(x), int'(e.x));
          chk("proc_y", int'(y), int'(e.y));
        end
      end
      if (out_valid && out_ready) begin
        ndrain++;
        if (drain_q.size() == 0) chk("drain_extra", 1, 0);
        else begin
          e = drain_q.pop_front();
          chk("drain_x", int'(x), int'(e.x));
          chk("drain_y", int'(y), int'(e.y));
        end
      end
      if (done) begin
        ndone++;
        done_busy = busy;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string p);
    chk({p, "_busy"}, int'(busy), 0);
    chk({p, "_x"}, int'(x), 0);
    chk({p, "_y"}, int'(y), 0);
    chk({p, "_filt"}, int'(filt_sel), 0);
    chk({p, "_in_ready"}, int'(in_ready), 0);
    chk({p, "_out_valid"}, int'(out_valid), 0);
    chk({p, "_load_en"}, int'(load_en), 0);
    chk({p, "_proc_en"}, int'(proc_en), 0);
    chk({p, "_done"}, int'(done), 0);
  endtask

  task automatic run_frame(input vec_t v);
    int cyc;
    int stall_cnt;
    fill_frame();
    exp_filt  = v.exp_filt;
    done_busy = 1'b0;
    start     = 1'b1;
    mode      = v.mode;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    start     = 1'b0;
    mode      = ~v.mode;  // must not reach filt_sel mid-frame
    cyc       = 0;
    stall_cnt = 0;
    while (ndone == 0 && cyc < 400) begin
      if (v.toggle) in_valid = (cyc % 2 == 0);
      out_ready = 1'b1;
      if (v.stall_idx >= 0 && ndrain == v.stall_idx && stall_cnt < v.stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
        #1;
        chk({v.name, "_stall_valid"}, int'(out_valid), 1);
        chk({v.name, "_stall_x"}, int'(x), v.stall_idx % W);
        chk({v.name, "_stall_y"}, int'(y), v.stall_idx / W);
      end
      step();
      cyc++;
    end
    if (ndone == 0) chk({v.name, "_timeout"}, 0, 1);
    chk({v.name, "_loads"}, nload, v.exp_loads);
    chk({v.name, "_procs"}, nproc, v.exp_procs);
    chk({v.name, "_drains"}, ndrain, v.exp_drains);
    chk({v.name, "_done_cnt"}, ndone, 1);
    chk({v.name, "_busy_at_done"}, int'(done_busy), 1);
    chk({v.name, "_busy_after"}, int'(busy), 0);
    chk({v.name, "_done_after"}, int'(done), 0);
    chk({v.name, "_filt_hold"}, int'(filt_sel), v.exp_filt);
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    tbl[0] = '{"basic_m1",  2'd1, 1'b0, -1, 0, 1, 12, 12, 12};
    tbl[1] = '{"toggle_m0", 2'd0, 1'b1, -1, 0, 0, 12, 12, 12};
    tbl[2] = '{"stall_m2",  2'd2, 1'b0,  6, 5, 2, 12, 12, 12};
    tbl[3] = '{"mix_m3",    2'd3, 1'b1, 11, 2, 3, 12, 12, 12};

    rst = 1'b1; start = 1'b0; mode = 2'd0; abort = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_idle("reset");

    foreach (tbl[i]) run_frame(tbl[i]);

    // Abort in PROC at (1,2): straight to IDLE with no done pulse.
    fill_frame();
    exp_filt = 2;
    start = 1'b1; mode = 2'd2;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(proc_en && x == 1 && y == 2) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("abort_reach_1_2", (proc_en && x == 1 && y == 2) ? 1 : 0, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_proc_en", int'(proc_en), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_x", int'(x), 0);
    chk("abort_y", int'(y), 0);
    ndone = 0;
    repeat (5) step();
    chk("abort_no_done", ndone, 0);
    run_frame(tbl[1]);

    // Abort while IDLE is ignored; abort once busy drops back to IDLE.
    in_valid = 1'b0;
    start = 1'b1; abort = 1'b1; mode = 2'd1;
    step();
    start = 1'b0;
    chk("idle_abort_ignored", int'(busy), 1);
    step();
    abort = 1'b0;
    chk("load_abort_busy", int'(busy), 0);
    chk("load_abort_filt", int'(filt_sel), 1);

    // Start while busy, then reset mid-DRAIN with abort and start also high.
    fill_frame();
    exp_filt = 3;
    in_valid = 1'b1;
    start = 1'b1; mode = 2'd3;
    step();
    out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      if (cyc == 3) begin start = 1'b1; mode = 2'd0; end
      else start = 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("drain_reached", int'(out_valid), 1);
    chk("busy_start_filt", int'(filt_sel), 3);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    out_ready = 1'b1;
    check_idle("rst_mid");
    repeat (4) step();
    chk("rst_no_resume", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
